decode_pipe_stage: RTL and testbench
====================================

Name: decode_pipe_stage

Overview:
- Parametrised next-generation decode stage: multi-port register file read, immediate extension and a D->E pipeline register in one block.
- Adds what the fixed-width stage lacks:
  - configurable register count and field positions
  - write-first bypass from writeback
  - stall and flush control
  - valid tracking
  - load-use hazard detection toward the fetch/decode control.
- Sits between fetch (InstrD, PCPlus1F) and execute; the writeback stage drives the write port.

Parameters:
- BITS, 24, datapath width.
- REG_ADDR_W, 4, register address width; register count = 2**REG_ADDR_W.
- IMM_W, 16, immediate field width taken from InstrD[IMM_W-1:0]; must be < BITS.
- RA1_LSB, 10, LSB of source/destination field A (RA1D = WA4D).
- RA2_LSB, 6, LSB of source field B.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-low.
- ValidD  in  1  InstrD holds a real instruction.
- InstrD  in  BITS  instruction in decode.
- PCPlus1F  in  BITS  value returned when the top register index (2**REG_ADDR_W-1) is read.
- ImmSrcD  in  1  0 = zero-extend, 1 = sign-extend the immediate.
- LoadD  in  1  instruction in decode is a load.
- StallD  in  1  hold the E-stage register.
- FlushE  in  1  insert a bubble into E.
- WE4  in  1  register-file write enable.
- WA4W  in  REG_ADDR_W  write address.
- ResultW  in  BITS  write data.
- RD1E, RD2E  out  BITS  registered operands.
- ExtImmE  out  BITS  registered extended immediate.
- WA4E  out  REG_ADDR_W  registered destination (field A).
- RA2E  out  REG_ADDR_W  registered source B address, for forwarding.
- LoadE  out  1  registered load flag.
- ValidE  out  1  E-stage holds a real instruction.
- HazardD  out  1  combinational load-use stall request.

Behaviour:
- Register file:
  - 2**REG_ADDR_W x BITS storage.
  - Write on the rising CLK edge when WE4=1 and RST=1; the top index is never written (writes to it are ignored).
  - Contents are not cleared by reset.
- Reads are combinational:
  - RA1D = InstrD[RA1_LSB+REG_ADDR_W-1:RA1_LSB]; RA2D likewise at RA2_LSB.
  - Read priority per port: top index -> PCPlus1F; else WE4=1 and WA4W==addr -> ResultW (write-first bypass); else stored value.
- Immediate:
  - ImmSrcD=0: zeros above InstrD[IMM_W-1:0].
  - ImmSrcD=1: InstrD[IMM_W-1] replicated up to BITS.
- E register (1-cycle latency, all outputs registered), priority per edge:
  - RST=0: all outputs 0, ValidE=0.
  - else FlushE=1: ValidE=0, LoadE=0, other fields don't-care but driven to 0.
  - else StallD=1: hold all fields.
  - else capture D values; ValidE=ValidD.
- FlushE together with StallD: flush wins.
- Register-file writes proceed regardless of StallD/FlushE.
- HazardD = ValidD & ValidE & LoadE & (WA4E==RA1D | WA4E==RA2D).
  - Purely combinational; does not self-stall. Control feeds it back as StallD plus FlushE next cycle.
- Reset mid-stall: reset wins; the held instruction is lost and ValidE=0.
- Any address read in the same cycle it is written returns ResultW, including when StallD=1.

Optional Feature:
- DECODE_ZERO_REG_EN defined:
  - Index 0 is hardwired: reads return 0, writes are ignored, no bypass on index 0.
  - HazardD ignores matches where WA4E==0.
- Not defined: index 0 is an ordinary register.

Decomposition:
- Package decode_pkg:
  - reg_addr_t typedef parameterised via localparam defaults.
  - imm_src_e enum {IMM_ZERO=0, IMM_SIGN=1}.
  - Constant TOP_REG for the PC-mapped index.
  - Struct de_pipe_t bundling RD1/RD2/ExtImm/WA4/RA2/Load/Valid for the E register.
- Sub-module decode_regfile: storage, two read ports, write-first bypass, top-index PC mapping and the DECODE_ZERO_REG_EN handling.
- Extension, pipeline register and hazard logic stay in decode_pipe_stage.

Test Plan:
1. Reset: hold RST=0 for 2 cycles with random inputs -> all outputs 0, ValidE=0. Release; next edge captures InstrD.
2. Bypass: WE4=1, WA4W=3, ResultW=0x00ABCD, InstrD with RA1D=3, same cycle -> RD1E=0x00ABCD after one edge. Following cycle, read R3 without a write -> 0x00ABCD.
3. PC read and extension: RA2D=15, PCPlus1F=0x000123 -> RD2E=0x000123. InstrD[15:0]=0x8001 with ImmSrcD=1 -> ExtImmE=0xFF8001; with ImmSrcD=0 -> 0x008001.
4. Stall/flush: StallD=1 for 3 cycles while InstrD changes -> E fields constant. StallD=1 and FlushE=1 together -> ValidE=0, LoadE=0.
5. Load-use: E holds a load with WA4E=5, ValidE=1; D has RA2D=5, ValidD=1 -> HazardD=1. Set ValidD=0 or RA1D/RA2D != 5 -> HazardD=0.
6. With DECODE_ZERO_REG_EN: write 0x111111 to R0 then read -> 0. Load with WA4E=0 against RA1D=0 -> HazardD=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the decode stage slice: address type, immediate mode,
// PC-mapped register index and the D->E pipeline bundle.
package decode_pkg;

    localparam int DP_BITS       = 24;
    localparam int DP_REG_ADDR_W = 4;

    typedef logic [DP_REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        IMM_ZERO = 1'b0,
        IMM_SIGN = 1'b1
    } imm_src_e;

    localparam reg_addr_t TOP_REG = '1;

    typedef struct packed {
        logic [DP_BITS-1:0] rd1;
        logic [DP_BITS-1:0] rd2;
        logic [DP_BITS-1:0] ext_imm;
        reg_addr_t          wa4;
        reg_addr_t          ra2;
        logic               load;
        logic               valid;
    } de_pipe_t;

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports, write-first bypass,
// PC-mapped top index and optional hardwired-zero R0 (DECODE_ZERO_REG_EN).
module decode_regfile
    import decode_pkg::*;
#(
    parameter int BITS       = DP_BITS,
    parameter int REG_ADDR_W = DP_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [BITS-1:0]       wd,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic [BITS-1:0]       pc,
    output logic [BITS-1:0]       rd1,
    output logic [BITS-1:0]       rd2
);

    localparam int NREG = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] TOP_IDX = TOP_REG;

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [BITS-1:0] mem [NREG];
    logic            wr_ok;

    // Top index is PC-mapped and R0 may be hardwired, so neither stores.
    always_comb begin
        wr_ok = we && (wa != TOP_IDX);
        if (ZERO_REG && wa == '0)
            wr_ok = 1'b0;
    end

    // Storage update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok)
            mem[wa] <= wd;
    end

    // Port 1: zero reg, then PC index, then same-cycle bypass, then storage.
    always_comb begin
        rd1 = mem[ra1];
        if (ZERO_REG && ra1 == '0)
            rd1 = '0;
        else if (ra1 == TOP_IDX)
            rd1 = pc;
        else if (we && wa == ra1)
            rd1 = wd;
    end

    // Port 2: same priority as port 1.
    always_comb begin
        rd2 = mem[ra2];
        if (ZERO_REG && ra2 == '0)
            rd2 = '0;
        else if (ra2 == TOP_IDX)
            rd2 = pc;
        else if (we && wa == ra2)
            rd2 = wd;
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage: regfile read, immediate extension, D->E register and
// load-use hazard detect. Option macro: DECODE_ZERO_REG_EN.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int BITS       = DP_BITS,
    parameter int REG_ADDR_W = DP_REG_ADDR_W,
    parameter int IMM_W      = 16,
    parameter int RA1_LSB    = 10,
    parameter int RA2_LSB    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ValidD,
    input  logic [BITS-1:0]       InstrD,
    input  logic [BITS-1:0]       PCPlus1F,
    input  logic                  ImmSrcD,
    input  logic                  LoadD,
    input  logic                  StallD,
    input  logic                  FlushE,
    input  logic                  WE4,
    input  logic [REG_ADDR_W-1:0] WA4W,
    input  logic [BITS-1:0]       ResultW,
    output logic [BITS-1:0]       RD1E,
    output logic [BITS-1:0]       RD2E,
    output logic [BITS-1:0]       ExtImmE,
    output logic [REG_ADDR_W-1:0] WA4E,
    output logic [REG_ADDR_W-1:0] RA2E,
    output logic                  LoadE,
    output logic                  ValidE,
    output logic                  HazardD
);

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [REG_ADDR_W-1:0] ra1_d;
    logic [REG_ADDR_W-1:0] ra2_d;
    logic [BITS-1:0]       rd1_d;
    logic [BITS-1:0]       rd2_d;
    logic [BITS-1:0]       ext_d;
    imm_src_e              imm_src;
    de_pipe_t              d_q;
    de_pipe_t              e_q;
    logic                  wa_hit;
    logic                  wa_live;

    assign ra1_d   = InstrD[RA1_LSB +: REG_ADDR_W];
    assign ra2_d   = InstrD[RA2_LSB +: REG_ADDR_W];
    assign imm_src = imm_src_e'(ImmSrcD);

    decode_regfile #(
        .BITS       (BITS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_rf (
        .clk   (CLK),
        .rst_n (RST),
        .we    (WE4),
        .wa    (WA4W),
        .wd    (ResultW),
        .ra1   (ra1_d),
        .ra2   (ra2_d),
        .pc    (PCPlus1F),
        .rd1   (rd1_d),
        .rd2   (rd2_d)
    );

    // Zero- or sign-extend the low immediate field to the datapath width.
    always_comb begin
        ext_d = {{(BITS-IMM_W){1'b0}}, InstrD[IMM_W-1:0]};
        if (imm_src == IMM_SIGN)
            ext_d = {{(BITS-IMM_W){InstrD[IMM_W-1]}}, InstrD[IMM_W-1:0]};
    end

    // Bundle the decode-side values that the E register captures.
    always_comb begin
        d_q         = '0;
        d_q.rd1     = rd1_d;
        d_q.rd2     = rd2_d;
        d_q.ext_imm = ext_d;
        d_q.wa4     = ra1_d;
        d_q.ra2     = ra2_d;
        d_q.load    = LoadD;
        d_q.valid   = ValidD;
    end

    // E register: reset, then flush (bubble), then stall (hold), else capture.
    always_ff @(posedge CLK) begin
        if (!RST)
            e_q <= '0;
        else if (FlushE)
            e_q <= '0;
        else if (!StallD)
            e_q <= d_q;
    end

    assign RD1E    = e_q.rd1;
    assign RD2E    = e_q.rd2;
    assign ExtImmE = e_q.ext_imm;
    assign WA4E    = e_q.wa4;
    assign RA2E    = e_q.ra2;
    assign LoadE   = e_q.load;
    assign ValidE  = e_q.valid;

    // Load-use detect: a load in E whose target is read by the live D instr.
    always_comb begin
        wa_hit  = (e_q.wa4 == ra1_d) || (e_q.wa4 == ra2_d);
        wa_live = 1'b1;
        if (ZERO_REG && e_q.wa4 == '0)
            wa_live = 1'b0;
        HazardD = ValidD && e_q.valid && e_q.load && wa_hit && wa_live;
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed literal cases plus
// randomized traffic checked against an array-based reference model.
module tb_decode_pipe_stage;

    localparam int BITS = 24;
    localparam int AW   = 4;
    localparam int NREG = 16;

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic            ValidD;
    logic [BITS-1:0] InstrD;
    logic [BITS-1:0] PCPlus1F;
    logic            ImmSrcD;
    logic            LoadD;
    logic            StallD;
    logic            FlushE;
    logic            WE4;
    logic [AW-1:0]   WA4W;
    logic [BITS-1:0] ResultW;
    logic [BITS-1:0] RD1E;
    logic [BITS-1:0] RD2E;
    logic [BITS-1:0] ExtImmE;
    logic [AW-1:0]   WA4E;
    logic [AW-1:0]   RA2E;
    logic            LoadE;
    logic            ValidE;
    logic            HazardD;

    int n_cmp = 0;
    int n_bad = 0;

    decode_pipe_stage dut (
        .CLK      (CLK),
        .RST      (RST),
        .ValidD   (ValidD),
        .InstrD   (InstrD),
        .PCPlus1F (PCPlus1F),
        .ImmSrcD  (ImmSrcD),
        .LoadD    (LoadD),
        .StallD   (StallD),
        .FlushE   (FlushE),
        .WE4      (WE4),
        .WA4W     (WA4W),
        .ResultW  (ResultW),
        .RD1E     (RD1E),
        .RD2E     (RD2E),
        .ExtImmE  (ExtImmE),
        .WA4E     (WA4E),
        .RA2E     (RA2E),
        .LoadE    (LoadE),
        .ValidE   (ValidE),
        .HazardD  (HazardD)
    );

    always #5 CLK = ~CLK;

    // Reference model state.
    logic [BITS-1:0] m_regs [NREG];
    logic [BITS-1:0] e_rd1 = '0, e_rd2 = '0, e_imm = '0;
    logic [AW-1:0]   e_wa = '0, e_ra2 = '0;
    logic            e_ld = 1'b0, e_v = 1'b0;

    function automatic logic [AW-1:0] fa(input logic [BITS-1:0] i);
        return AW'(i >> 10);
    endfunction

    function automatic logic [AW-1:0] fb(input logic [BITS-1:0] i);
        return AW'(i >> 6);
    endfunction

    function automatic logic [BITS-1:0] mread(input logic [AW-1:0] a);
        if (ZR && a == 0) return '0;
        if (a == AW'(NREG - 1)) return PCPlus1F;
        if (WE4 && WA4W == a) return ResultW;
        return m_regs[a];
    endfunction

    function automatic logic [BITS-1:0] mext(input logic [BITS-1:0] i,
                                             input logic s);
        int v;
        logic [15:0] lo;
        lo = i[15:0];
        if (s) v = int'($signed(lo));
        else   v = int'(lo);
        return v[BITS-1:0];
    endfunction

    // Model update at each rising edge.
    always @(posedge CLK) begin
        if (!RST || FlushE) begin
            e_rd1 = '0; e_rd2 = '0; e_imm = '0;
            e_wa = '0; e_ra2 = '0; e_ld = 1'b0; e_v = 1'b0;
        end else if (!StallD) begin
            e_rd1 = mread(fa(InstrD));
            e_rd2 = mread(fb(InstrD));
            e_imm = mext(InstrD, ImmSrcD);
            e_wa  = fa(InstrD);
            e_ra2 = fb(InstrD);
            e_ld  = LoadD;
            e_v   = ValidD;
        end
        if (RST && WE4 && WA4W != AW'(NREG - 1) && !(ZR && WA4W == 0))
            m_regs[WA4W] = ResultW;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        logic haz;
        haz = ValidD && e_v && e_ld &&
              (e_wa == fa(InstrD) || e_wa == fb(InstrD)) &&
              !(ZR && e_wa == 0);
        chk("m_rd1", 32'(RD1E), 32'(e_rd1));
        chk("m_rd2", 32'(RD2E), 32'(e_rd2));
        chk("m_imm", 32'(ExtImmE), 32'(e_imm));
        chk("m_wa4", 32'(WA4E), 32'(e_wa));
        chk("m_ra2", 32'(RA2E), 32'(e_ra2));
        chk("m_load", 32'(LoadE), 32'(e_ld));
        chk("m_valid", 32'(ValidE), 32'(e_v));
        chk("m_haz", 32'(HazardD), 32'(haz));
    end

    task automatic idle();
        ValidD = 0; InstrD = '0; ImmSrcD = 0; LoadD = 0;
        StallD = 0; FlushE = 0; WE4 = 0; WA4W = '0; ResultW = '0;
    endtask

    task automatic rnd_inputs();
        ValidD   = 1'($urandom);
        InstrD   = BITS'($urandom);
        PCPlus1F = BITS'($urandom);
        ImmSrcD  = 1'($urandom);
        LoadD    = 1'($urandom);
        StallD   = ($urandom_range(0, 3) == 0);
        FlushE   = ($urandom_range(0, 7) == 0);
        WE4      = 1'($urandom);
        WA4W     = AW'($urandom);
        ResultW  = BITS'($urandom);
    endtask

    initial begin
        RST = 0;
        PCPlus1F = '0;
        idle();
        // Reset with random inputs for two edges.
        for (int i = 0; i < 2; i++) begin
            rnd_inputs();
            @(negedge CLK);
            chk("rst_valid", 32'(ValidE), 32'd0);
            chk("rst_rd1", 32'(RD1E), 32'd0);
            #1;
        end
        RST = 1;
        idle();
        // Preload R0..R14 while reading only the PC-mapped index.
        for (int r = 0; r < NREG - 1; r++) begin
            InstrD = 24'h003FC0;
            PCPlus1F = BITS'($urandom);
            ValidD = 1;
            WE4 = 1; WA4W = AW'(r); ResultW = BITS'($urandom);
            @(negedge CLK); #1;
        end
        chk("rst_release_valid", 32'(ValidE), 32'd1);
        // Same-cycle write-first bypass to R3, PC read on port B.
        idle();
        ValidD = 1; InstrD = 24'h000FC0; PCPlus1F = 24'h000123;
        WE4 = 1; WA4W = 4'd3; ResultW = 24'h00ABCD;
        @(negedge CLK);
        chk("bypass_rd1", 32'(RD1E), 32'h00ABCD);
        chk("pc_rd2", 32'(RD2E), 32'h000123);
        #1;
        WE4 = 0;
        @(negedge CLK);
        chk("stored_rd1", 32'(RD1E), 32'h00ABCD);
        #1;
        // Immediate extension.
        InstrD = 24'h008001; ImmSrcD = 1;
        @(negedge CLK);
        chk("imm_sign", 32'(ExtImmE), 32'hFF8001);
        #1;
        ImmSrcD = 0;
        @(negedge CLK);
        chk("imm_zero", 32'(ExtImmE), 32'h008001);
        #1;
        // Stall three cycles while D changes.
        StallD = 1;
        for (int i = 0; i < 3; i++) begin
            InstrD = BITS'($urandom); ImmSrcD = 1'($urandom);
            LoadD = 1'($urandom);
            @(negedge CLK);
            chk("stall_imm", 32'(ExtImmE), 32'h008001);
            chk("stall_valid", 32'(ValidE), 32'd1);
            #1;
        end
        FlushE = 1; LoadD = 1;
        @(negedge CLK);
        chk("flush_valid", 32'(ValidE), 32'd0);
        chk("flush_load", 32'(LoadE), 32'd0);
        #1;
        // Load-use: load to R5 in E, then D reads R5 under stall.
        idle();
        ValidD = 1; LoadD = 1; InstrD = 24'h001400;
        @(negedge CLK); #1;
        StallD = 1; LoadD = 0; InstrD = 24'h000540;
        @(negedge CLK);
        chk("haz_hit", 32'(HazardD), 32'd1);
        #1;
        ValidD = 0;
        @(negedge CLK);
        chk("haz_invalid", 32'(HazardD), 32'd0);
        #1;
        ValidD = 1; InstrD = 24'h000580;
        @(negedge CLK);
        chk("haz_miss", 32'(HazardD), 32'd0);
        #1;
        // R0 write/read and load to R0 hazard.
        idle();
        ValidD = 1; InstrD = 24'h0003C0;
        WE4 = 1; WA4W = 4'd0; ResultW = 24'h111111;
        @(negedge CLK);
        chk("r0_bypass", 32'(RD1E), ZR ? 32'd0 : 32'h111111);
        #1;
        WE4 = 0; LoadD = 1;
        @(negedge CLK);
        chk("r0_read", 32'(RD1E), ZR ? 32'd0 : 32'h111111);
        #1;
        StallD = 1; LoadD = 0;
        @(negedge CLK);
        chk("r0_haz", 32'(HazardD), ZR ? 32'd0 : 32'd1);
        #1;
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rnd_inputs();
            RST = ($urandom_range(0, 63) != 0);
            @(negedge CLK); #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
